pipelined_processing_unit: RTL and testbench

PIPELINED_PROCESSING_UNIT -- requirements
Module: pipelined_processing_unit

---
 rtl/pipelined_processing_unit.sv | 110 +++++++++++
 tb/tb_pipelined_processing_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pipelined_processing_unit.sv
// -----------------------------------------------------------------------------
// pipelined_processing_unit
//
// Three-stage byte-logic pipeline followed by a match counter. Every clock
// out of reset the 32-bit input word is split into four bytes a..d, and the
// pipeline computes
//   stage 1 : a, b, c, d captured
//   stage 2 : P = a & b, Q = c ^ d, R = a ^ b, S = ~(c & d)
//   stage 3 : E = P | Q, F = R & S
// One edge after a valid stage-3 result appears, match_count increments if
// E == F. Throughput is one sample per clock, with no stalls.
//
// Ports
//   clk          : single clock, rising-edge triggered
//   rst          : asynchronous, active-high reset
//   counter      : 32-bit data word, sampled every clock while out of reset
//   valid_out    : high while the stage-3 E/F registers hold a valid sample
//   match_count  : running count of samples with E == F (CNT_W bits)
//
// Parameters
//   CNT_W        : width of match_count (default 16)
//
// Configuration macro
//   PPU_SAT_EN   : when defined, match_count saturates at all-ones and holds.
//                  When undefined, it wraps from all-ones to zero.
// -----------------------------------------------------------------------------
module pipelined_processing_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      counter,
  output logic             valid_out,
  output logic [CNT_W-1:0] match_count
);

  // Stage 1: raw bytes
  logic [7:0] a_q, b_q, c_q, d_q;
  logic       v1_q;
  // Stage 2: partial logic terms
  logic [7:0] p_q, q_q, r_q, s_q;
  logic       v2_q;
  // Stage 3: compared operands
  logic [7:0] e_q, f_q;
  logic       v3_q;

  logic       hit;

  // NOTE: every pipeline register, valid bit included, is cleared by reset.
  // This is what discards in-flight samples when reset arrives mid-stream.
  // Clearing only the valid bits would also be enough, but clearing all of
  // them keeps state visible in simulation deterministic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q  <= '0;
      b_q  <= '0;
      c_q  <= '0;
      d_q  <= '0;
      v1_q <= 1'b0;
      p_q  <= '0;
      q_q  <= '0;
      r_q  <= '0;
      s_q  <= '0;
      v2_q <= 1'b0;
      e_q  <= '0;
      f_q  <= '0;
      v3_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let each stage read the previous
      // stage's value from before this edge. That is what creates the
      // pipeline registers instead of collapsing them into one combinational
      // path.
      a_q  <= counter[7:0];
      b_q  <= counter[15:8];
      c_q  <= counter[23:16];
      d_q  <= counter[31:24];
      v1_q <= 1'b1;  // input is valid every cycle out of reset

      p_q  <= a_q & b_q;
      q_q  <= c_q ^ d_q;
      r_q  <= a_q ^ b_q;
      s_q  <= ~(c_q & d_q);
      v2_q <= v1_q;

      e_q  <= p_q | q_q;
      f_q  <= r_q & s_q;
      v3_q <= v2_q;
    end
  end

  assign valid_out = v3_q;

  // Bubbles (v3 = 0) are ignored, even though their zeroed E/F compare equal.
  assign hit = v3_q && (e_q == f_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_count <= '0;
    end else if (hit) begin
`ifdef PPU_SAT_EN
      if (match_count != {CNT_W{1'b1}}) begin
        match_count <= match_count + CNT_W'(1);
      end
`else
      match_count <= match_count + CNT_W'(1);  // wraps all-ones -> 0
`endif
    end
  end

endmodule

// File: tb/tb_pipelined_processing_unit.sv
// -----------------------------------------------------------------------------
// tb_pipelined_processing_unit
//
// Self-checking bench for pipelined_processing_unit. Two instances share one
// stimulus stream: the default-width DUT (CNT_W = 16) and a narrow one
// (CNT_W = 4) that exercises the count wrap or saturation limit.
//
// A scoreboard queue holds the expected match flag of every sample taken.
// The flag is computed from the bench's own model of the byte logic. Once
// three samples are in flight, each new edge retires the oldest one into the
// expected counts. Outputs are compared 1 time unit after every rising edge.
// -----------------------------------------------------------------------------
module tb_pipelined_processing_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] counter = '0;

  logic        valid_out;
  logic [15:0] match_count;
  logic        small_valid;
  logic [3:0]  small_count;

  int n_cmp = 0;
  int n_err = 0;

  bit          sb[$];       // expected match flags of samples in flight
  logic [15:0] exp_count;
  logic [3:0]  exp_small;

  pipelined_processing_unit #(.CNT_W(16)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .counter     (counter),
    .valid_out   (valid_out),
    .match_count (match_count)
  );

  pipelined_processing_unit #(.CNT_W(4)) u_small (
    .clk         (clk),
    .rst         (rst),
    .counter     (counter),
    .valid_out   (small_valid),
    .match_count (small_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model of the byte logic: does word w produce E == F?
  function automatic bit model_match(input logic [31:0] w);
    logic [7:0] a, b, c, d, e, f;
    a = w[7:0];
    b = w[15:8];
    c = w[23:16];
    d = w[31:24];
    e = (a & b) | (c ^ d);
    f = (a ^ b) & ~(c & d);
    return e == f;
  endfunction

  // Count one expected match in the model.
  // Both counters follow the build's wrap or saturation behaviour.
  task automatic model_count();
`ifdef PPU_SAT_EN
    if (exp_count != 16'hFFFF) exp_count++;
    if (exp_small != 4'hF) exp_small++;
`else
    exp_count++;
    exp_small++;
`endif
  endtask

  // Apply one word for one clock, update the model, and compare all outputs.
  task automatic step(input logic [31:0] w);
    counter = w;
    @(posedge clk);
    if (!rst) begin
      if (sb.size() >= 3) begin
        if (sb.pop_front()) model_count();
      end
      sb.push_back(model_match(w));
    end
    #1;
    check("valid_out", {31'b0, valid_out}, {31'b0, sb.size() >= 3});
    check("small_valid", {31'b0, small_valid}, {31'b0, sb.size() >= 3});
    check("match_count", {16'b0, match_count}, {16'b0, exp_count});
    check("small_count", {28'b0, small_count}, {28'b0, exp_small});
  endtask

  // Assert reset between edges and check that outputs clear with no edge.
  // Hold reset for two edges, then release it 1 unit after an edge.
  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    exp_count = '0;
    exp_small = '0;
    #1;
    check("async_rst_valid", {31'b0, valid_out}, 32'd0);
    check("async_rst_count", {16'b0, match_count}, 32'd0);
    step(32'h1122_3344);
    step(32'h1122_3344);
    rst = 1'b0;
  endtask

  localparam logic [31:0] NOMATCH [5] = '{32'h1122_3344, 32'hAABB_CCDD,
                                          32'h0102_0304, 32'hFFFF_FFFF,
                                          32'h1234_5678};
  localparam logic [31:0] SEQ [6] = '{32'h1122_3344, 32'hAABB_CCDD,
                                      32'h0102_0304, 32'hFFFF_FFFF,
                                      32'h0000_0000, 32'h1234_5678};

  logic [15:0] base;

  initial begin
    exp_count = '0;
    exp_small = '0;
    #2;

    // Reset: outputs clear while reset is held across edges
    do_reset();
    check("rst_hold_valid", {31'b0, valid_out}, 32'd0);
    check("rst_hold_count", {16'b0, match_count}, 32'd0);

    // Non-matching vectors, 4 cycles each, then flush the pipeline
    for (int i = 0; i < 5; i++)
      for (int k = 0; k < 4; k++) step(NOMATCH[i]);
    for (int k = 0; k < 3; k++) step(32'h1122_3344);
    check("nomatch_count", {16'b0, match_count}, 32'd0);

    // Full sequence, 4 cycles each, then 10 idle cycles
    do_reset();
    for (int i = 0; i < 6; i++)
      for (int k = 0; k < 4; k++) step(SEQ[i]);
    for (int k = 0; k < 10; k++) step(32'h1122_3344);
    check("seq_final", {16'b0, match_count}, 32'd4);

    // Latency: one matching word between non-matching words
    base = exp_count;
    step(32'hAABB_CCDD);
    step(32'h5A5A_0000);          // edge N
    step(32'hAABB_CCDD);          // N+1
    check("lat_n1_count", {16'b0, match_count}, {16'b0, base});
    step(32'hAABB_CCDD);          // N+2: the sample reaches stage 3
    check("lat_n2_valid", {31'b0, valid_out}, 32'd1);
    check("lat_n2_count", {16'b0, match_count}, {16'b0, base});
    step(32'hAABB_CCDD);          // N+3: count increments
    check("lat_n3_count", {16'b0, match_count}, {16'b0, base} + 32'd1);

    // Mid-stream reset with matching words in flight
    step(32'h0000_0000);
    step(32'h0000_0000);
    do_reset();
    step(32'h0000_0000);          // first edge after release
    step(32'h0000_0000);
    step(32'h0000_0000);          // edge 3: valid, no count yet
    check("resume_e3_valid", {31'b0, valid_out}, 32'd1);
    check("resume_e3_count", {16'b0, match_count}, 32'd0);
    step(32'h0000_0000);          // edge 4: first increment
    check("resume_e4_count", {16'b0, match_count}, 32'd1);

    // Count limit on the 4-bit instance: 20 matches
    do_reset();
    for (int k = 0; k < 20; k++) step(32'h0000_0000);
    for (int k = 0; k < 3; k++) step(32'h1122_3344);
    check("limit_wide", {16'b0, match_count}, 32'd20);
`ifdef PPU_SAT_EN
    check("limit_small", {28'b0, small_count}, 32'd15);
`else
    check("limit_small", {28'b0, small_count}, 32'd4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
